// File: rtl/eth_mac_10g_tx_arb.sv
// Packet-granular round-robin arbiter in front of the 10G MAC transmit AXI-stream port.
// A grant is held from a packet's first beat through its tlast beat; output is a 2-entry skid slice.
module eth_mac_10g_tx_arb #(
   parameter int PORTS      = 4,
   parameter int DATA_WIDTH = 64,
   parameter int KEEP_WIDTH = DATA_WIDTH/8,
   parameter int USER_WIDTH = 1,
   parameter int SEL_WIDTH  = $clog2(PORTS)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [PORTS*DATA_WIDTH-1:0]      s_axis_tdata,
   input  logic [PORTS*KEEP_WIDTH-1:0]      s_axis_tkeep,
   input  logic [PORTS-1:0]                 s_axis_tvalid,
   output logic [PORTS-1:0]                 s_axis_tready,
   input  logic [PORTS-1:0]                 s_axis_tlast,
   input  logic [PORTS*USER_WIDTH-1:0]      s_axis_tuser,
   output logic [DATA_WIDTH-1:0]            m_axis_tdata,
   output logic [KEEP_WIDTH-1:0]            m_axis_tkeep,
   output logic                             m_axis_tvalid,
   input  logic                             m_axis_tready,
   output logic                             m_axis_tlast,
   output logic [USER_WIDTH-1:0]            m_axis_tuser,
   input  logic                             link_up,
   input  logic [PORTS-1:0]                 port_enable,
   output logic                             grant_valid,
   output logic [SEL_WIDTH-1:0]             grant_index
);

   localparam int BW = DATA_WIDTH + KEEP_WIDTH + USER_WIDTH + 1;

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t               state, state_next;
   logic [SEL_WIDTH-1:0] grant_q, grant_next, last_grant, pick;
   logic                 pick_found;
   logic [PORTS-1:0]     req, ready_q, ready_next;

   logic [BW-1:0]        in_beat, main_beat, temp_beat;
   logic                 in_xfer, in_last;
   logic                 main_valid, temp_valid, main_valid_next, temp_valid_next;
   logic                 load_main_in, load_main_temp, load_temp;

   assign req = s_axis_tvalid & port_enable & {PORTS{link_up}};

   // Search order starts one past the previous winner and wraps modulo PORTS.
   always_comb begin
      int idx;
      logic [SEL_WIDTH-1:0] cand;
      pick       = '0;
      pick_found = 1'b0;
      idx        = 0;
      cand       = '0;
      for (int k = 1; k <= PORTS; k++) begin
         idx  = (int'(last_grant) + k) % PORTS;
         cand = idx[SEL_WIDTH-1:0];
         if (!pick_found && req[cand]) begin
            pick       = cand;
            pick_found = 1'b1;
         end
      end
   end

   assign in_beat = {s_axis_tlast[grant_q],
                     s_axis_tuser[int'(grant_q)*USER_WIDTH +: USER_WIDTH],
                     s_axis_tkeep[int'(grant_q)*KEEP_WIDTH +: KEEP_WIDTH],
                     s_axis_tdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH]};
   assign in_last = s_axis_tlast[grant_q];
   assign in_xfer = |(s_axis_tvalid & ready_q);

   always_comb begin
      state_next      = state;
      grant_next      = grant_q;
      main_valid_next = main_valid;
      temp_valid_next = temp_valid;
      load_main_in    = 1'b0;
      load_main_temp  = 1'b0;
      load_temp       = 1'b0;
      ready_next      = '0;

      case (state)
         IDLE: if (pick_found) begin
            state_next = ACTIVE;
            grant_next = pick;
         end
         ACTIVE: if (in_xfer && in_last) state_next = IDLE;
         default: state_next = IDLE;
      endcase

      // Ready high guarantees temp is empty, so an input beat lands in main or temp.
      if (|ready_q) begin
         if (m_axis_tready || !main_valid) begin
            main_valid_next = in_xfer;
            load_main_in    = in_xfer;
         end else begin
            temp_valid_next = in_xfer;
            load_temp       = in_xfer;
         end
      end else if (m_axis_tready) begin
         main_valid_next = temp_valid;
         load_main_temp  = temp_valid;
         temp_valid_next = 1'b0;
      end

      if (state_next == ACTIVE && !temp_valid_next) ready_next[grant_next] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         grant_q    <= '0;
         last_grant <= SEL_WIDTH'(PORTS-1);
         ready_q    <= '0;
         main_valid <= 1'b0;
         temp_valid <= 1'b0;
         main_beat  <= '0;
         temp_beat  <= '0;
      end else begin
         state      <= state_next;
         grant_q    <= grant_next;
         ready_q    <= ready_next;
         main_valid <= main_valid_next;
         temp_valid <= temp_valid_next;
         if (state == IDLE && pick_found) last_grant <= pick;
         if (load_main_in)        main_beat <= in_beat;
         else if (load_main_temp) main_beat <= temp_beat;
         if (load_temp)           temp_beat <= in_beat;
      end
   end

   assign s_axis_tready = ready_q;
   assign m_axis_tvalid = main_valid;
   assign {m_axis_tlast, m_axis_tuser, m_axis_tkeep, m_axis_tdata} = main_beat;
   assign grant_valid   = (state == ACTIVE);
   assign grant_index   = grant_q;

endmodule
